// File: rtl/irig_frame_decoder.sv
// IRIG time-code frame decoder: hunts for the double-MARK frame reference,
// captures FRAME_LEN symbols, checks MARK positions, and publishes the frame
// and its BCD time fields.
// Latency: outputs are registered; frame_valid and issue pulse one cycle
//   after the edge that completes the frame or detects the error.
// Backpressure: none. A symbol is consumed on every edge with sym_valid && en.
// Ports:
//   clk, hrd_rst_n (async, active-low), en, sym_valid, sym[1:0]
//   state, sym_idx, frame_bits, time_sec/min/hour/day/year,
//   frame_valid, locked, issue, err_cnt
module irig_frame_decoder #(
  parameter int FRAME_LEN   = 100,
  parameter int LOCK_N      = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 hrd_rst_n,
  input  logic                 en,
  input  logic                 sym_valid,
  input  logic [1:0]           sym,
  output logic [1:0]           state,
  output logic [6:0]           sym_idx,
  output logic [FRAME_LEN-1:0] frame_bits,
  output logic [6:0]           time_sec,
  output logic [6:0]           time_min,
  output logic [5:0]           time_hour,
  output logic [9:0]           time_day,
  output logic [7:0]           time_year,
  output logic                 frame_valid,
  output logic                 locked,
  output logic                 issue,
  output logic [7:0]           err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_HUNT  = 2'd0,
    S_MARK1 = 2'd1,
    S_RECV  = 2'd2,
    S_END   = 2'd3
  } st_e;

  localparam logic [1:0] SYM_ONE  = 2'b01;
  localparam logic [1:0] SYM_MARK = 2'b10;

  st_e                  state_q;
  logic [6:0]           idx_q;
  logic [FRAME_LEN-1:0] cap_q;
  logic [FRAME_LEN-1:0] frame_q;
  logic [TW-1:0]        tmo_q;
  logic [3:0]           good_q;
  logic                 fv_q, iss_q, lock_q;
  logic [7:0]           err_q;
  logic [6:0]           sec_q, min_q;
  logic [5:0]           hour_q;
  logic [9:0]           day_q;
  logic [7:0]           year_q;

  logic                 acc, is_mark, is_data, want_mark, sym_ok;
  logic                 tmo_hit, err_ev, last;
  logic [FRAME_LEN-1:0] cap_d;
  logic [3:0]           good_d;

  always_comb begin
    acc       = sym_valid & en;
    is_mark   = (sym == SYM_MARK);
    is_data   = ~sym[1];
    // END only ever accepts the next frame's reference MARK
    want_mark = (state_q == S_END) || ((idx_q % 7'd10) == 7'd9);
    sym_ok    = want_mark ? is_mark : is_data;
    // Fires on the edge that would make the idle count reach TIMEOUT_CYC;
    // an accepted symbol on that same edge takes precedence.
    tmo_hit   = (state_q != S_HUNT) && !acc && (tmo_q == TW'(TIMEOUT_CYC - 1));
    err_ev    = en && ((state_q == S_RECV) || (state_q == S_END)) &&
                ((acc && !sym_ok) || tmo_hit);
    last      = (idx_q == 7'(FRAME_LEN - 1));
    cap_d     = cap_q;
    cap_d[idx_q] = (sym == SYM_ONE);
    good_d    = (good_q == 4'(LOCK_N)) ? good_q : good_q + 4'd1;
  end

  always_ff @(posedge clk or negedge hrd_rst_n) begin
    if (!hrd_rst_n) begin
      state_q <= S_HUNT;
      idx_q   <= '0;
      cap_q   <= '0;
      frame_q <= '0;
      tmo_q   <= '0;
      good_q  <= '0;
      fv_q    <= 1'b0;
      iss_q   <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      day_q   <= '0;
      year_q  <= '0;
    end else begin
      fv_q  <= 1'b0;
      iss_q <= 1'b0;
      tmo_q <= (state_q == S_HUNT || acc) ? '0 : tmo_q + TW'(1);
      if (!en) begin
        // Disable wins over any symbol presented in the same cycle.
        state_q <= S_HUNT;
        idx_q   <= '0;
        tmo_q   <= '0;
        good_q  <= '0;
        lock_q  <= 1'b0;
      end else if (err_ev) begin
        state_q <= S_HUNT;
        idx_q   <= '0;
        tmo_q   <= '0;
        good_q  <= '0;
        lock_q  <= 1'b0;
        iss_q   <= 1'b1;
        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
      end else begin
        unique case (state_q)
          S_HUNT: begin
            if (acc && is_mark) state_q <= S_MARK1;
          end
          S_MARK1: begin
            if (acc) begin
              if (is_mark) begin
                state_q <= S_RECV;
                idx_q   <= 7'd1;
                cap_q   <= '0;
              end else begin
                state_q <= S_HUNT;
              end
            end else if (tmo_hit) begin
              // Not yet synchronised, so a stall here is not reported.
              state_q <= S_HUNT;
              tmo_q   <= '0;
            end
          end
          S_RECV: begin
            if (acc) begin
              cap_q <= cap_d;
              if (last) begin
                state_q <= S_END;
                idx_q   <= '0;
                frame_q <= cap_d;
                // Highest field bit is symbol 58, inside the 60-symbol minimum.
                sec_q   <= {cap_d[8:6],   cap_d[4:1]};
                min_q   <= {cap_d[17:15], cap_d[13:10]};
                hour_q  <= {cap_d[26:25], cap_d[23:20]};
                day_q   <= {cap_d[41:40], cap_d[38:35], cap_d[33:30]};
                year_q  <= {cap_d[58:55], cap_d[53:50]};
                fv_q    <= 1'b1;
                good_q  <= good_d;
                lock_q  <= (good_d == 4'(LOCK_N));
              end else begin
                idx_q <= idx_q + 7'd1;
              end
            end
          end
          S_END: begin
            if (acc) begin
              state_q <= S_RECV;
              idx_q   <= 7'd1;
              cap_q   <= '0;
            end
          end
          default: state_q <= S_HUNT;
        endcase
      end
    end
  end

  assign state       = state_q;
  assign sym_idx     = idx_q;
  assign frame_bits  = frame_q;
  assign time_sec    = sec_q;
  assign time_min    = min_q;
  assign time_hour   = hour_q;
  assign time_day    = day_q;
  assign time_year   = year_q;
  assign frame_valid = fv_q;
  assign locked      = lock_q;
  assign issue       = iss_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_irig_frame_decoder.sv
// Bench for irig_frame_decoder: table of single-symbol steps, directed
// multi-cycle sequences, and randomized frames against a frame-level model.
module tb_irig_frame_decoder;
  localparam int FL = 100;
  localparam int LN = 3;
  localparam int TC = 20;

  localparam logic [1:0] ZERO = 2'd0, ONE = 2'd1, MARK = 2'd2, INV = 2'd3;

  logic          clk = 1'b0;
  logic          hrd_rst_n = 1'b0;
  logic          en = 1'b0, sym_valid = 1'b0;
  logic [1:0]    sym = 2'd0;
  logic [1:0]    state;
  logic [6:0]    sym_idx;
  logic [FL-1:0] frame_bits;
  logic [6:0]    time_sec, time_min;
  logic [5:0]    time_hour;
  logic [9:0]    time_day;
  logic [7:0]    time_year;
  logic          frame_valid, locked, issue;
  logic [7:0]    err_cnt;

  irig_frame_decoder #(.FRAME_LEN(FL), .LOCK_N(LN), .TIMEOUT_CYC(TC)) dut (
    .clk(clk), .hrd_rst_n(hrd_rst_n), .en(en), .sym_valid(sym_valid), .sym(sym),
    .state(state), .sym_idx(sym_idx), .frame_bits(frame_bits),
    .time_sec(time_sec), .time_min(time_min), .time_hour(time_hour),
    .time_day(time_day), .time_year(time_year), .frame_valid(frame_valid),
    .locked(locked), .issue(issue), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0;
  int fv_cnt = 0, iss_cnt = 0;

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (issue) iss_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step(input logic e, input logic v, input logic [1:0] s);
    @(negedge clk);
    en = e; sym_valid = v; sym = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " state"}, state, 0);
    chk({tag, " sym_idx"}, sym_idx, 0);
    chk({tag, " frame_bits"}, frame_bits, 0);
    chk({tag, " time_sec"}, time_sec, 0);
    chk({tag, " time_min"}, time_min, 0);
    chk({tag, " time_hour"}, time_hour, 0);
    chk({tag, " time_day"}, time_day, 0);
    chk({tag, " time_year"}, time_year, 0);
    chk({tag, " frame_valid"}, frame_valid, 0);
    chk({tag, " locked"}, locked, 0);
    chk({tag, " issue"}, issue, 0);
    chk({tag, " err_cnt"}, err_cnt, 0);
  endtask

  // Frame bit vector for a decimal time, LSB-first BCD at the IRIG-B positions.
  function automatic logic [FL-1:0] enc_time(input int s, input int m, input int h,
                                              input int d, input int y);
    logic [FL-1:0] v = '0;
    for (int i = 0; i < 4; i++) begin
      v[1+i]  = 1'(((s % 10) >> i) & 1);
      v[10+i] = 1'(((m % 10) >> i) & 1);
      v[20+i] = 1'(((h % 10) >> i) & 1);
      v[30+i] = 1'(((d % 10) >> i) & 1);
      v[35+i] = 1'((((d / 10) % 10) >> i) & 1);
      v[50+i] = 1'(((y % 10) >> i) & 1);
      v[55+i] = 1'((((y / 10) % 10) >> i) & 1);
    end
    for (int i = 0; i < 3; i++) begin
      v[6+i]  = 1'(((s / 10) >> i) & 1);
      v[15+i] = 1'(((m / 10) >> i) & 1);
    end
    for (int i = 0; i < 2; i++) begin
      v[25+i] = 1'(((h / 10) >> i) & 1);
      v[40+i] = 1'(((d / 100) >> i) & 1);
    end
    return v;
  endfunction

  function automatic logic [1:0] sym_at(input logic [FL-1:0] v, input int i);
    if (i == 0 || (i % 10) == 9) return MARK;
    return v[i] ? ONE : ZERO;
  endfunction

  task automatic send_frame(input logic [FL-1:0] v, input int gap_max);
    for (int i = 0; i < FL; i++) begin
      repeat ($urandom_range(0, gap_max)) step(1'b1, 1'b0, 2'($urandom));
      step(1'b1, 1'b1, sym_at(v, i));
    end
  endtask

  typedef struct {
    logic       e;
    logic       v;
    logic [1:0] s;
    logic [1:0] st;
    logic [6:0] idx;
    logic       iss;
    logic [7:0] err;
  } vec_t;

  vec_t tbl[18];

  logic [FL-1:0] v1, v2, fb;
  int exp_err, fv0, iss0, consec, corrupt, k;
  logic in_end, broke;
  logic [1:0] ws;

  initial begin
    tbl[0]  = '{1'b1, 1'b1, ZERO, 2'd0, 7'd0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 1'b1, MARK, 2'd1, 7'd0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 1'b1, ONE,  2'd0, 7'd0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 1'b1, MARK, 2'd1, 7'd0, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 1'b0, MARK, 2'd1, 7'd0, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b1, MARK, 2'd0, 7'd0, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 1'b1, MARK, 2'd1, 7'd0, 1'b0, 8'd0};
    tbl[7]  = '{1'b1, 1'b1, MARK, 2'd2, 7'd1, 1'b0, 8'd0};
    tbl[8]  = '{1'b1, 1'b1, ZERO, 2'd2, 7'd2, 1'b0, 8'd0};
    tbl[9]  = '{1'b1, 1'b1, ONE,  2'd2, 7'd3, 1'b0, 8'd0};
    tbl[10] = '{1'b1, 1'b1, INV,  2'd0, 7'd0, 1'b1, 8'd1};
    tbl[11] = '{1'b1, 1'b1, MARK, 2'd1, 7'd0, 1'b0, 8'd1};
    tbl[12] = '{1'b1, 1'b1, MARK, 2'd2, 7'd1, 1'b0, 8'd1};
    tbl[13] = '{1'b1, 1'b1, MARK, 2'd0, 7'd0, 1'b1, 8'd2};
    tbl[14] = '{1'b1, 1'b1, MARK, 2'd1, 7'd0, 1'b0, 8'd2};
    tbl[15] = '{1'b1, 1'b1, MARK, 2'd2, 7'd1, 1'b0, 8'd2};
    tbl[16] = '{1'b0, 1'b1, ONE,  2'd0, 7'd0, 1'b0, 8'd2};
    tbl[17] = '{1'b1, 1'b1, INV,  2'd0, 7'd0, 1'b0, 8'd2};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    hrd_rst_n = 1'b1;

    // Table of single-symbol steps
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].e, tbl[i].v, tbl[i].s);
      chk($sformatf("tbl%0d state", i), state, tbl[i].st);
      chk($sformatf("tbl%0d sym_idx", i), sym_idx, tbl[i].idx);
      chk($sformatf("tbl%0d issue", i), issue, tbl[i].iss);
      chk($sformatf("tbl%0d err_cnt", i), err_cnt, tbl[i].err);
    end
    exp_err = 2;

    // Three good frames encoding 23:59:58, day 365, year 19
    v1 = enc_time(58, 59, 23, 365, 19);
    fv0 = fv_cnt; iss0 = iss_cnt;
    step(1'b1, 1'b1, MARK);
    for (int f = 0; f < 3; f++) begin
      send_frame(v1, 1);
      chk($sformatf("f%0d frame_valid", f), frame_valid, 1);
      chk($sformatf("f%0d frame_bits", f), frame_bits, v1);
      chk($sformatf("f%0d locked", f), locked, (f == 2) ? 1 : 0);
      chk($sformatf("f%0d state", f), state, 3);
      chk($sformatf("f%0d sym_idx", f), sym_idx, 0);
    end
    chk("time_hour", time_hour, 6'h23);
    chk("time_min", time_min, 7'h59);
    chk("time_sec", time_sec, 7'h58);
    chk("time_day", time_day, 10'h365);
    chk("time_year", time_year, 8'h19);
    step(1'b1, 1'b0, 2'd0);
    chk("frame_valid pulses", fv_cnt - fv0, 3);
    chk("no issue on good frames", iss_cnt - iss0, 0);

    // ONE where a MARK belongs (index 29) while locked
    iss0 = iss_cnt;
    for (int i = 0; i < 29; i++) step(1'b1, 1'b1, sym_at(v1, i));
    step(1'b1, 1'b1, ONE);
    exp_err++;
    chk("idx29 issue", issue, 1);
    chk("idx29 state", state, 0);
    chk("idx29 locked", locked, 0);
    chk("idx29 err_cnt", err_cnt, exp_err);
    chk("idx29 time_hour kept", time_hour, 6'h23);
    chk("idx29 time_day kept", time_day, 10'h365);
    chk("idx29 frame_bits kept", frame_bits, v1);
    step(1'b1, 1'b0, 2'd0);
    chk("idx29 single issue", iss_cnt - iss0, 1);

    // Timeout in MARK1: silent return to HUNT
    step(1'b1, 1'b1, MARK);
    repeat (TC - 1) step(1'b1, 1'b0, 2'd0);
    chk("mark1 pre-timeout state", state, 1);
    step(1'b1, 1'b0, 2'd0);
    chk("mark1 timeout state", state, 0);
    chk("mark1 timeout issue", issue, 0);
    chk("mark1 timeout err_cnt", err_cnt, exp_err);

    // Timeout in RECV
    step(1'b1, 1'b1, MARK);
    step(1'b1, 1'b1, MARK);
    repeat (TC - 1) step(1'b1, 1'b0, 2'd0);
    chk("recv pre-timeout state", state, 2);
    chk("recv pre-timeout issue", issue, 0);
    step(1'b1, 1'b0, 2'd0);
    exp_err++;
    chk("recv timeout state", state, 0);
    chk("recv timeout issue", issue, 1);
    chk("recv timeout err_cnt", err_cnt, exp_err);

    // Symbol exactly on the timeout edge wins
    step(1'b1, 1'b1, MARK);
    step(1'b1, 1'b1, MARK);
    repeat (TC - 1) step(1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b1, ZERO);
    chk("edge symbol state", state, 2);
    chk("edge symbol sym_idx", sym_idx, 2);
    chk("edge symbol issue", issue, 0);
    chk("edge symbol err_cnt", err_cnt, exp_err);
    step(1'b0, 1'b0, 2'd0);

    // en dropped at index 50 with a valid symbol
    iss0 = iss_cnt;
    step(1'b1, 1'b1, MARK);
    for (int i = 0; i < 50; i++) step(1'b1, 1'b1, sym_at(v1, i));
    chk("pre-en0 sym_idx", sym_idx, 50);
    step(1'b0, 1'b1, sym_at(v1, 50));
    chk("en0 state", state, 0);
    chk("en0 sym_idx", sym_idx, 0);
    chk("en0 issue", issue, 0);
    chk("en0 err_cnt", err_cnt, exp_err);
    chk("en0 frame_bits kept", frame_bits, v1);
    step(1'b1, 1'b0, 2'd0);
    chk("en0 still hunt", state, 0);
    chk("en0 no issue pulse", iss_cnt - iss0, 0);

    // Randomized frames against the frame-level model
    consec = 0; in_end = 1'b0;
    for (int ep = 0; ep < 12; ep++) begin
      if (!in_end) step(1'b1, 1'b1, MARK);
      k = $urandom_range(1, 3);
      broke = 1'b0;
      for (int f = 0; f < k && !broke; f++) begin
        fb = '0;
        for (int i = 1; i < FL; i++) if ((i % 10) != 9) fb[i] = 1'($urandom_range(0, 1));
        corrupt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, FL - 1) : -1;
        for (int i = 0; i < FL; i++) begin
          repeat ($urandom_range(0, 2)) step(1'b1, 1'b0, 2'($urandom));
          if (i == corrupt) begin
            if ((i % 10) == 9) begin
              ws = 2'($urandom_range(0, 2));
              if (ws == 2'd2) ws = INV;
            end else begin
              ws = $urandom_range(0, 1) ? MARK : INV;
            end
            step(1'b1, 1'b1, ws);
            if (exp_err < 255) exp_err++;
            consec = 0; in_end = 1'b0; broke = 1'b1;
            chk($sformatf("rnd%0d err issue", ep), issue, 1);
            chk($sformatf("rnd%0d err state", ep), state, 0);
            chk($sformatf("rnd%0d err err_cnt", ep), err_cnt, exp_err);
            chk($sformatf("rnd%0d err locked", ep), locked, 0);
            break;
          end
          step(1'b1, 1'b1, sym_at(fb, i));
        end
        if (!broke) begin
          consec++; in_end = 1'b1;
          chk($sformatf("rnd%0d frame_valid", ep), frame_valid, 1);
          chk($sformatf("rnd%0d frame_bits", ep), frame_bits, fb);
          chk($sformatf("rnd%0d locked", ep), locked, (consec >= LN) ? 1 : 0);
          chk($sformatf("rnd%0d state", ep), state, 3);
        end
      end
    end
    step(1'b0, 1'b0, 2'd0);

    // 256 forced errors: err_cnt saturates
    iss0 = iss_cnt;
    repeat (256) begin
      step(1'b1, 1'b1, MARK);
      step(1'b1, 1'b1, MARK);
      step(1'b1, 1'b1, MARK);
    end
    chk("err_cnt saturated", err_cnt, 255);
    step(1'b1, 1'b0, 2'd0);
    chk("forced error issues", iss_cnt - iss0, 256);
    chk("err_cnt holds", err_cnt, 255);

    // Asynchronous reset mid-frame
    step(1'b1, 1'b1, MARK);
    for (int i = 0; i < 21; i++) step(1'b1, 1'b1, sym_at(v1, i));
    #2;
    hrd_rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    sym_valid = 1'b0;
    fv0 = fv_cnt; iss0 = iss_cnt;
    repeat (3) @(negedge clk);
    hrd_rst_n = 1'b1;
    step(1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b0, 2'd0);
    chk("post-reset no pulses", (fv_cnt - fv0) + (iss_cnt - iss0), 0);
    chk("post-reset state", state, 0);

    v2 = enc_time(12, 34, 5, 123, 24);
    step(1'b1, 1'b1, MARK);
    send_frame(v2, 1);
    chk("pair1 frame_valid", frame_valid, 1);
    send_frame(v2, 1);
    chk("pair2 frame_valid", frame_valid, 1);
    chk("pair2 frame_bits", frame_bits, v2);
    chk("pair2 time_min", time_min, 7'h34);
    chk("pair2 time_hour", time_hour, 6'h05);
    chk("pair2 time_day", time_day, 10'h123);
    chk("pair2 time_year", time_year, 8'h24);
    chk("pair2 locked", locked, 0);
    chk("pair2 err_cnt", err_cnt, 0);
    step(1'b1, 1'b0, 2'd0);
    chk("pair frame_valid count", fv_cnt - fv0, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/irig_frame_decoder.md
IRIG_FRAME_DECODER -- requirements
Module: irig_frame_decoder

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- FRAME_LEN, 100: symbols per frame; multiple of 10, range 60..100.
- LOCK_N, 3: consecutive good frames needed to assert locked; range 1..15.
- TIMEOUT_CYC, 1000: maximum clk cycles between accepted symbols outside HUNT; must be at least 2.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on its rising edge.
- hrd_rst_n, in, 1: reset; asynchronous assert, active-low.
- en, in, 1: decoder enable.
- sym_valid, in, 1: sym is valid this cycle.
- sym, in, 2: symbol code; 00 = ZERO, 01 = ONE, 10 = MARK, 11 = INVALID.
- state, out, 2: FSM state; HUNT = 0, MARK1 = 1, RECV = 2, END = 3.
- sym_idx, out, 7: index of the next expected symbol within the frame.
- frame_bits, out, FRAME_LEN: last complete frame; bit k = 1 if and only if symbol k was ONE.
- time_sec, out, 7: BCD seconds; symbols 1-4 are units, 6-8 are tens.
- time_min, out, 7: BCD minutes; symbols 10-13 are units, 15-17 are tens.
- time_hour, out, 6: BCD hours; symbols 20-23 are units, 25-26 are tens.
- time_day, out, 10: BCD day; symbols 30-33, 35-38 and 40-41.
- time_year, out, 8: BCD year; symbols 50-53 and 55-58.
- frame_valid, out, 1: one-cycle pulse when a frame completes.
- locked, out, 1: LOCK_N consecutive good frames have been seen.
- issue, out, 1: one-cycle pulse when an error is detected.
- err_cnt, out, 8: saturating error counter.

Function
REQ-003 A symbol SHALL be accepted only on a clock edge where sym_valid=1 and en=1.
REQ-004 In HUNT, an accepted MARK SHALL move the FSM to MARK1; any other symbol SHALL leave it in HUNT with no issue pulse.
REQ-005 In MARK1, an accepted MARK (the frame reference, index 0) SHALL move the FSM to RECV with sym_idx=1; any other symbol SHALL return the FSM to HUNT with no issue pulse.
REQ-006 In RECV, at sym_idx where sym_idx mod 10 = 9, the block SHALL expect MARK; at every other index it SHALL expect ZERO or ONE.
REQ-007 In RECV, an expected symbol SHALL shift into an internal capture register at position sym_idx, and sym_idx SHALL increment by 1.
REQ-008 In RECV, a MARK accepted at sym_idx = FRAME_LEN-1 SHALL complete the frame, and the FSM SHALL move to END.
REQ-009 On frame completion, the block SHALL load frame_bits and all time_* fields from the capture register on that same edge.
REQ-010 On frame completion, frame_valid SHALL be 1 for exactly the following cycle.
REQ-011 Field bits at positions at or beyond FRAME_LEN SHALL read 0; with FRAME_LEN=60, time_year is valid.
REQ-012 In END, an accepted MARK SHALL move the FSM to RECV with sym_idx=1, giving back-to-back frames with no gap.
REQ-013 An error is any of the following; on an error the FSM SHALL go to HUNT, issue SHALL pulse for 1 cycle, err_cnt SHALL increment (saturating at 255), and the good-frame count and locked SHALL clear:
- a wrong symbol class in RECV or END;
- an INVALID symbol in RECV or END;
- a timeout.
REQ-014 Timeout: a cycle counter SHALL reset on every accepted symbol and hold at 0 in HUNT; when it reaches TIMEOUT_CYC in MARK1, RECV or END, the block SHALL flag a timeout error.
REQ-015 A timeout flagged in MARK1 SHALL return the FSM to HUNT without an issue pulse.
REQ-016 If an accepted symbol and a timeout coincide on the same edge, the symbol SHALL win and no timeout error SHALL occur.
REQ-017 Lock: the good-frame count SHALL increment at each frame completion and saturate at LOCK_N; locked SHALL equal (count == LOCK_N) and SHALL be registered.
REQ-018 en=0 SHALL force HUNT on the next edge, zero sym_idx and the timeout counter, and clear locked, with no issue pulse and no err_cnt change.
REQ-019 en=0 SHALL take priority over a symbol that is valid in the same cycle.
REQ-020 frame_bits and time_* SHALL hold their last values until the next frame completion; errors and en=0 SHALL NOT clear them.
REQ-021 sym_idx SHALL read 0 in HUNT and MARK1, and FRAME_LEN-1+1 wrap to 0 in END.

Reset
REQ-022 hrd_rst_n=0 SHALL immediately, without waiting for a clock edge, force the following values:
- state = HUNT;
- sym_idx, frame_bits, all time_*, err_cnt, the good-frame count, the timeout counter and the capture register = 0;
- frame_valid, issue and locked = 0.
REQ-023 The block SHALL release from reset on the first clk edge after hrd_rst_n rises.
REQ-024 Asserting reset mid-frame SHALL discard the partial frame, and no frame_valid or issue pulse SHALL follow.

Verification
REQ-025 The bench SHALL drive 3 valid IRIG-B frames (FRAME_LEN=100, LOCK_N=3) encoding 23:59:58, day 365, year 19 -> frame_valid pulses 3 times, and locked rises after the third frame with time_hour=6'h23, time_min=7'h59, time_sec=7'h58, time_day=10'h365, time_year=8'h19.
REQ-026 The bench SHALL, while locked, send ONE at index 29 -> issue pulses once, err_cnt increments by 1, locked=0, state=HUNT, and time_* keep their last values.
REQ-027 The bench SHALL send MARK, MARK, then stop sym_valid for TIMEOUT_CYC cycles -> issue pulses, state=HUNT; a repeat with a symbol exactly on the timeout cycle -> no error.
REQ-028 The bench SHALL send 256 forced errors -> err_cnt saturates at 255.
REQ-029 The bench SHALL drop en to 0 at index 50 while sym_valid=1 -> state=HUNT, no issue pulse, err_cnt unchanged, symbol ignored.
REQ-030 The bench SHALL assert hrd_rst_n=0 mid-frame between clock edges -> all outputs read 0 immediately, and the next full frame pair decodes normally.
